// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// UART receiver using 16x oversampling. The serial line is synchronized,
// a falling edge on the idle line starts a frame, and every bit is resolved
// by a 2-of-3 majority vote of oversamples 7, 8 and 9. Data arrives LSB
// first. The result and its error flags are reported with a one-cycle
// rx_valid pulse at the middle of the last stop bit. The receiver returns
// to IDLE at that point, so a frame that follows with no idle gap is caught.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one EVEN parity bit follows the data; a mismatch sets parity_err
//   undefined : no parity bit is expected and parity_err is tied low
//
// Parameters
//   CLK_HZ       input clock frequency in Hz
//   BIT_RATE     serial bit rate in bit/s
//   PAYLOAD_BITS data bits per frame (5..9)
//   STOP_BITS    stop bits checked per frame (1 or 2)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   uart_rx_in asynchronous serial line, idle high
//   rx_data    last received payload
//   rx_valid   one-cycle pulse: rx_data and the error flags are fresh
//   frame_err  a stop bit was sampled low in the reported frame
//   parity_err parity mismatch in the reported frame
//   break_det  line held low for a whole frame; clears on the next high sample
//   rx_busy    high whenever the receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx_in,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    break_det,
  output logic                    rx_busy
);

  localparam int OS_DIV = CLK_HZ / (BIT_RATE * 16);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic                    rxMeta_q, rxSync_q, rxPrev_q;
  logic [1:0]              syncLive_q;
  logic [DIV_W-1:0]        divCnt_q, divCnt_d;
  state_e                  state_q, state_d;
  logic [3:0]              sampleCnt_q, sampleCnt_d;
  logic [3:0]              bitIdx_q, bitIdx_d;
  logic                    stopIdx_q, stopIdx_d;
  logic                    s7_q, s7_d, s8_q, s8_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    frameAcc_q, frameAcc_d;
  logic [PAYLOAD_BITS-1:0] rxData_q, rxData_d;
  logic                    rxValid_q, rxValid_d;
  logic                    frameErr_q, frameErr_d;
  logic                    breakDet_q, breakDet_d;
`ifdef UART_RX_PARITY_EN
  logic                    parityAcc_q, parityAcc_d;
  logic                    parityErr_q, parityErr_d;
`endif

  logic tick, majority, startEdge, frameErrNow;

  assign tick        = (divCnt_q == DIV_W'(OS_DIV - 1));
  assign majority    = (s7_q & s8_q) | (s7_q & rxSync_q) | (s8_q & rxSync_q);
  // rxPrev_q is only ever 1 after a real high sample, so the reset value of
  // the synchronizer can never look like a falling edge after reset release.
  assign startEdge   = rxPrev_q & ~rxSync_q;
  assign frameErrNow = frameAcc_q | ~majority;

  // Next-state logic: tick divider, frame FSM, and output capture.
  always_comb begin
    divCnt_d    = tick ? '0 : divCnt_q + DIV_W'(1);
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q;
    bitIdx_d    = bitIdx_q;
    stopIdx_d   = stopIdx_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    shift_d     = shift_q;
    frameAcc_d  = frameAcc_q;
    rxData_d    = rxData_q;
    rxValid_d   = 1'b0;
    frameErr_d  = frameErr_q;
    breakDet_d  = breakDet_q & ~rxSync_q;
`ifdef UART_RX_PARITY_EN
    parityAcc_d = parityAcc_q;
    parityErr_d = parityErr_q;
`endif

    if (state_q != IDLE && tick) begin
      sampleCnt_d = sampleCnt_q + 4'd1;
      if (sampleCnt_q == 4'd7) s7_d = rxSync_q;
      if (sampleCnt_q == 4'd8) s8_d = rxSync_q;
    end

    case (state_q)
      IDLE: begin
        if (startEdge && !breakDet_q) begin
          state_d     = START;
          sampleCnt_d = 4'd0;
          frameAcc_d  = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          if (sampleCnt_q == 4'd9 && majority) begin
            state_d     = IDLE;
            sampleCnt_d = 4'd0;
          end else if (sampleCnt_q == 4'd15) begin
            state_d  = DATA;
            bitIdx_d = 4'd0;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sampleCnt_q == 4'd9) begin
            shift_d = {majority, shift_q[PAYLOAD_BITS-1:1]};
          end else if (sampleCnt_q == 4'd15) begin
            if (bitIdx_q == 4'(PAYLOAD_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
              stopIdx_d = 1'b0;
            end else begin
              bitIdx_d = bitIdx_q + 4'd1;
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          // Even parity: data bits plus parity bit must have an even count of ones.
          if (sampleCnt_q == 4'd9) begin
            parityAcc_d = (^shift_q) ^ majority;
          end else if (sampleCnt_q == 4'd15) begin
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (sampleCnt_q == 4'd9) begin
            if (stopIdx_q == 1'(STOP_BITS - 1)) begin
              // Report at mid stop bit and leave at once so a following
              // start edge is not missed.
              rxValid_d   = 1'b1;
              rxData_d    = shift_q;
              frameErr_d  = frameErrNow;
`ifdef UART_RX_PARITY_EN
              parityErr_d = parityAcc_q;
`endif
              if (frameErrNow && (shift_q == '0)) breakDet_d = 1'b1;
              state_d     = IDLE;
              sampleCnt_d = 4'd0;
            end else begin
              frameAcc_d = frameErrNow;
            end
          end else if (sampleCnt_q == 4'd15) begin
            stopIdx_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        sampleCnt_d = 4'd0;
      end
    endcase
  end

  // State and datapath registers, plus the two-flop line synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q    <= 1'b1;
      rxSync_q    <= 1'b1;
      syncLive_q  <= 2'b00;
      rxPrev_q    <= 1'b0;
      divCnt_q    <= '0;
      state_q     <= IDLE;
      sampleCnt_q <= 4'd0;
      bitIdx_q    <= 4'd0;
      stopIdx_q   <= 1'b0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= '0;
      frameAcc_q  <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      breakDet_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityAcc_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxMeta_q    <= uart_rx_in;
      rxSync_q    <= rxMeta_q;
      syncLive_q  <= {syncLive_q[0], 1'b1};
      rxPrev_q    <= rxSync_q & syncLive_q[1];
      divCnt_q    <= divCnt_d;
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      bitIdx_q    <= bitIdx_d;
      stopIdx_q   <= stopIdx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      frameAcc_q  <= frameAcc_d;
      rxData_q    <= rxData_d;
      rxValid_q   <= rxValid_d;
      frameErr_q  <= frameErr_d;
      breakDet_q  <= breakDet_d;
`ifdef UART_RX_PARITY_EN
      parityAcc_q <= parityAcc_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign break_det = breakDet_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16
// Testbench for uart_rx_os16 at 1.536 MHz / 9600 baud, which gives 160 clocks
// per bit. Each frame the bench sends also pushes the report it should
// produce into a queue. A monitor pops one entry on every rx_valid. Between
// reports, the monitor checks that rx_data and the error flags hold their
// last reported values.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

  localparam int CLK_HZ   = 1_536_000;
  localparam int BIT_RATE = 9600;
  localparam int BIT_CLKS = 160;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uartLine = 1'b1;
  logic [7:0] rxData;
  logic       rxValid, frameErr, parityErr, breakDet, rxBusy;

  int   vectors = 0;
  int   miscompares = 0;
  int   validCnt = 0;
  int   cyc = 0;
  exp_t expQ[$];
  logic [7:0] heldData = 8'h00;
  logic       heldFe = 1'b0;
  logic       heldPe = 1'b0;

  uart_rx_os16 #(
    .CLK_HZ(CLK_HZ),
    .BIT_RATE(BIT_RATE),
    .PAYLOAD_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx_in(uartLine),
    .rx_data(rxData),
    .rx_valid(rxValid),
    .frame_err(frameErr),
    .parity_err(parityErr),
    .break_det(breakDet),
    .rx_busy(rxBusy)
  );

  always #5 clk = ~clk;

  // Counts clocks since reset release, matching the free-running divider.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds the line waveform for one frame and queues its expected report.
  // resetPos >= 0 pulses rst_n in the middle of that bit position, so no
  // report is expected.
  task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                               input logic stopLevel, input int resetPos);
    logic bits [0:11];
    int   n = 0;
    exp_t e;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = data[i];
`ifdef UART_RX_PARITY_EN
    bits[n++] = parBit;
    e.pe = (^data) ^ parBit;
`else
    e.pe = 1'b0;
`endif
    bits[n++] = stopLevel;
    e.data = data;
    e.fe   = ~stopLevel;
    e.brk  = ~stopLevel && (data == 8'h00);
    if (resetPos < 0) expQ.push_back(e);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (c == 0) uartLine = bits[b];
        if (b == resetPos && c == 80) rst_n = 1'b0;
        if (b == resetPos && c == 85) rst_n = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    uartLine = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  // Monitor: pops one expected report per rx_valid, otherwise checks hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        heldData = 8'h00;
        heldFe   = 1'b0;
        heldPe   = 1'b0;
      end else if (rxValid) begin
        validCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rx_valid", rxValid, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rx_data", rxData, e.data);
          checkOutput("frame_err", frameErr, e.fe);
          checkOutput("parity_err", parityErr, e.pe);
          checkOutput("break_det", breakDet, e.brk);
          heldData = e.data;
          heldFe   = e.fe;
          heldPe   = e.pe;
        end
      end else begin
        checkOutput("hold", {rxData, frameErr, parityErr}, {heldData, heldFe, heldPe});
      end
    end
  end

  initial begin
    int v0;
    repeat (5) @(negedge clk);
    checkOutput("reset_rx_busy", rxBusy, 1'b0);
    checkOutput("reset_rx_valid", rxValid, 1'b0);
    checkOutput("reset_rx_data", rxData, 8'h00);
    checkOutput("reset_frame_err", frameErr, 1'b0);
    checkOutput("reset_parity_err", parityErr, 1'b0);
    checkOutput("reset_break_det", breakDet, 1'b0);
    rst_n = 1'b1;
    idle(50);

    $display("[TB] frame 0x55");
    v0 = validCnt;
    applyStimulus(8'h55, 1'b0, 1'b1, -1);
    idle(40);
    waitDrain(400);
    checkOutput("x55_pulses", validCnt - v0, 1);
    checkOutput("x55_data", rxData, 8'h55);
    checkOutput("x55_frame_err", frameErr, 1'b0);
    checkOutput("x55_parity_err", parityErr, 1'b0);

    $display("[TB] 40-clock glitch");
    v0 = validCnt;
    while (cyc % 10 != 6) @(negedge clk);
    uartLine = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_busy_start", rxBusy, 1'b1);
    repeat (30) @(negedge clk);
    uartLine = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("glitch_busy_at_100", rxBusy, 1'b0);
    idle(300);
    checkOutput("glitch_pulses", validCnt - v0, 0);

    $display("[TB] frame 0xA3 with low stop bit");
    v0 = validCnt;
    applyStimulus(8'hA3, 1'b0, 1'b0, -1);
    idle(40);
    waitDrain(400);
    checkOutput("xa3_pulses", validCnt - v0, 1);
    checkOutput("xa3_data", rxData, 8'hA3);
    checkOutput("xa3_frame_err", frameErr, 1'b1);
    checkOutput("xa3_break_det", breakDet, 1'b0);
    idle(200);

    $display("[TB] break: line low for 2000 clocks");
    v0 = validCnt;
    expQ.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0, brk: 1'b1});
    uartLine = 1'b0;
    repeat (1900) @(negedge clk);
    checkOutput("break_set", breakDet, 1'b1);
    checkOutput("break_data", rxData, 8'h00);
    checkOutput("break_frame_err", frameErr, 1'b1);
    repeat (100) @(negedge clk);
    idle(20);
    checkOutput("break_cleared", breakDet, 1'b0);
    idle(2000);
    checkOutput("break_pulses", validCnt - v0, 1);
    checkOutput("break_busy", rxBusy, 1'b0);
    waitDrain(10);

    $display("[TB] back-to-back 0x01, 0xFE");
    v0 = validCnt;
    applyStimulus(8'h01, 1'b1, 1'b1, -1);
    applyStimulus(8'hFE, 1'b1, 1'b1, -1);
    idle(40);
    waitDrain(400);
    checkOutput("b2b_pulses", validCnt - v0, 2);
    checkOutput("b2b_last_data", rxData, 8'hFE);
    checkOutput("b2b_frame_err", frameErr, 1'b0);

    $display("[TB] reset in the middle of data");
    v0 = validCnt;
    applyStimulus(8'h07, 1'b1, 1'b1, 4);
    idle(300);
    checkOutput("rst_pulses", validCnt - v0, 0);
    checkOutput("rst_busy", rxBusy, 1'b0);
    checkOutput("rst_data", rxData, 8'h00);
    v0 = validCnt;
    applyStimulus(8'h3C, 1'b0, 1'b1, -1);
    idle(40);
    waitDrain(400);
    checkOutput("after_rst_pulses", validCnt - v0, 1);
    checkOutput("after_rst_data", rxData, 8'h3C);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks on 0x07");
    applyStimulus(8'h07, 1'b0, 1'b1, -1);
    idle(40);
    waitDrain(400);
    checkOutput("par_bad", parityErr, 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b1, -1);
    idle(40);
    waitDrain(400);
    checkOutput("par_good", parityErr, 1'b0);
`endif

    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-005 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port uart_rx_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data  output  PAYLOAD_BITS  last received payload, LSB first on line.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data and error flags valid.
REQ-010 SHALL have port frame_err  output  1  stop bit sampled low in the frame just reported.
REQ-011 SHALL have port parity_err  output  1  parity mismatch in the frame just reported.
REQ-012 SHALL have port break_det  output  1  level: line held low for a full frame, cleared on next high sample.
REQ-013 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass uart_rx_in through a two-flop synchronizer, reset value 1, before any use.
REQ-015 SHALL generate a tick enable every OS_DIV = CLK_HZ/(BIT_RATE*16) clocks, counter free-running from reset.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP with a 4-bit sample counter (0..15) per bit.
REQ-017 IDLE->START on synchronized falling edge (high then low); sample counter cleared to 0.
REQ-018 SHALL decide each bit value by 2-of-3 majority of samples 7, 8, 9 on ticks.
REQ-019 START: majority 1 at sample 9 -> IDLE (false start, no rx_valid); majority 0 -> DATA after sample 15.
REQ-020 DATA: shift PAYLOAD_BITS bits LSB first; -> PARITY if parity compiled in, else STOP.
REQ-021 STOP: check STOP_BITS bits; at sample 9 of last stop bit assert rx_valid for exactly one clk, then IDLE immediately (no wait for sample 15).
REQ-022 frame_err SHALL be 1 if any stop bit majority is 0; flags and rx_data SHALL update only in the rx_valid cycle and hold until the next one.
REQ-023 break_det SHALL set in the rx_valid cycle when frame_err=1 and all data bits are 0; while set, IDLE SHALL not re-arm until line sampled high.
REQ-024 A falling edge during STOP after rx_valid SHALL start a new frame (back-to-back frames with zero idle supported).

Reset
REQ-025 On rst_n low: state IDLE, counters 0, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, break_det 0, rx_busy 0, synchronizer 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame without rx_valid; after release receiver re-arms only on a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state samples one parity bit after data; EVEN parity; mismatch sets parity_err.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity bit expected, parity_err tied 0.

Verification (CLK_HZ=1_536_000, BIT_RATE=9600: OS_DIV=10, 160 clk/bit)
REQ-029 Frame 0x55, 1 stop -> single rx_valid pulse, rx_data=0x55, frame_err=0, parity_err=0.
REQ-030 Low glitch of 40 clk on idle line -> no rx_valid, state back to IDLE, rx_busy low by start+100 clk.
REQ-031 Frame 0xA3 with stop bit forced low -> rx_valid, rx_data=0xA3, frame_err=1, break_det=0.
REQ-032 Line low for 2000 clk -> rx_valid, rx_data=0x00, frame_err=1, break_det=1; clears after line high, no second rx_valid.
REQ-033 Frames 0x01 then 0xFE with zero idle gap -> two rx_valid pulses, data 0x01 then 0xFE, no errors.
REQ-034 With UART_RX_PARITY_EN, frame 0x07 sent with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0; rst_n pulsed mid-data -> no rx_valid.
